// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command/response bundle between the sensor sequencer and the I2C byte engine
interface i2c_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [6:0] slave_addr;
  logic       mode;
  logic [7:0] write_data;
  logic       ack_out;
  logic       done;
  logic       ack_err;
  logic       cmd_err;
  logic [7:0] read_data;
  logic       bus_owned;

  modport master (
    output cmd_valid, cmd, slave_addr, mode, write_data, ack_out,
    input  cmd_ready, done, ack_err, cmd_err, read_data, bus_owned
  );

  modport slave (
    input  cmd_valid, cmd, slave_addr, mode, write_data, ack_out,
    output cmd_ready, done, ack_err, cmd_err, read_data, bus_owned
  );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - single-master I2C byte engine: START+addr, WRITE, READ, STOP on open-drain lines
module i2c_byte_master #(
  parameter int DIV = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  i2c_byte_master_if.slave bus,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in
);
  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;
  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_ACK, S_STOP, S_DONE} state_t;

  state_t     state;
  logic [1:0] quarter;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [1:0] op;
  logic       ack_out_r;
  logic       ack_sample;

  logic phase_end, is_read, tx_bit, next_tx_bit, ack_bit;
  assign phase_end   = (div_cnt == DIV_LAST);
  assign is_read     = (op == CMD_READ);
  assign tx_bit      = is_read | tx_sr[7];
  assign next_tx_bit = is_read | tx_sr[6];
  assign ack_bit     = !is_read | ack_out_r;

  // {scl_oe, sda_oe} for quarter q of a state; b is the line level wanted on SDA for a bit slot
  function automatic logic [1:0] lines(input state_t st, input logic [1:0] q, input logic b);
    case (st)
      S_START: lines = {(q == 2'd0) || (q == 2'd3), q[1]};
      S_STOP:  lines = {q == 2'd0, !q[1]};
      default: lines = {(q == 2'd0) || (q == 2'd3), !b};
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      quarter       <= 2'd0;
      div_cnt       <= 8'd0;
      bit_cnt       <= 3'd0;
      tx_sr         <= 8'd0;
      rx_sr         <= 8'd0;
      op            <= 2'd0;
      ack_out_r     <= 1'b0;
      ack_sample    <= 1'b0;
      scl_oe        <= 1'b0;
      sda_oe        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.ack_err   <= 1'b0;
      bus.cmd_err   <= 1'b0;
      bus.read_data <= 8'd0;
      bus.bus_owned <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.cmd_valid) begin
            op        <= bus.cmd;
            ack_out_r <= bus.ack_out;
            quarter   <= 2'd0;
            // the accept cycle itself is the first clock of quarter 0
            div_cnt   <= 8'd1;
            if (bus.cmd != CMD_START && !bus.bus_owned) begin
              state       <= S_DONE;
              bus.done    <= 1'b1;
              bus.cmd_err <= 1'b1;
              bus.ack_err <= 1'b0;
            end else begin
              bus.cmd_ready <= 1'b0;
              case (bus.cmd)
                CMD_START: begin
                  state            <= S_START;
                  tx_sr            <= {bus.slave_addr, bus.mode};
                  {scl_oe, sda_oe} <= lines(S_START, 2'd0, 1'b1);
                end
                CMD_STOP: begin
                  state            <= S_STOP;
                  {scl_oe, sda_oe} <= lines(S_STOP, 2'd0, 1'b1);
                end
                default: begin
                  state            <= S_BITS;
                  bit_cnt          <= 3'd7;
                  tx_sr            <= bus.write_data;
                  {scl_oe, sda_oe} <= lines(S_BITS, 2'd0, (bus.cmd == CMD_READ) || bus.write_data[7]);
                end
              endcase
            end
          end
        end
        default: begin
          if (phase_end && quarter == 2'd2) begin
            if (state == S_BITS) rx_sr <= {rx_sr[6:0], sda_in};
            if (state == S_ACK) ack_sample <= sda_in;
          end
          if (!phase_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            quarter <= quarter + 2'd1;
            if (quarter != 2'd3) begin
              {scl_oe, sda_oe} <= lines(state, quarter + 2'd1, (state == S_ACK) ? ack_bit : tx_bit);
            end else begin
              case (state)
                S_START: begin
                  state            <= S_BITS;
                  bit_cnt          <= 3'd7;
                  {scl_oe, sda_oe} <= lines(S_BITS, 2'd0, tx_bit);
                end
                S_BITS: begin
                  tx_sr <= {tx_sr[6:0], 1'b0};
                  if (bit_cnt == 3'd0) begin
                    state            <= S_ACK;
                    {scl_oe, sda_oe} <= lines(S_ACK, 2'd0, ack_bit);
                  end else begin
                    bit_cnt          <= bit_cnt - 3'd1;
                    {scl_oe, sda_oe} <= lines(S_BITS, 2'd0, next_tx_bit);
                  end
                end
                S_ACK: begin
                  state         <= S_DONE;
                  bus.done      <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  bus.cmd_err   <= 1'b0;
                  bus.ack_err   <= !is_read && ack_sample;
                  if (is_read) bus.read_data <= rx_sr;
                  if (op == CMD_START) bus.bus_owned <= 1'b1;
                end
                default: begin
                  state         <= S_DONE;
                  bus.done      <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  bus.cmd_err   <= 1'b0;
                  bus.ack_err   <= 1'b0;
                  bus.bus_owned <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C master engine sitting directly below the sensor write/read sequencer.
- Turns byte commands into open-drain SCL/SDA waveforms: START+address, WRITE byte, READ byte, STOP.
- Returns per-command completion, slave ACK status and read data to the sequencer.
- Single master only: no arbitration and no clock stretching.

Parameters:
DIV, 4, clock cycles per quarter SCL period (legal range 2 to 255); one bit period = 4*DIV clocks

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, command accepted when cmd_valid&&cmd_ready
cmd  in  2  command code: 0 START+ADDR, 1 WRITE, 2 READ, 3 STOP
slave_addr  in  7  target address, used by START
mode  in  1  R/W bit sent after address (1 = read), used by START
write_data  in  8  byte for WRITE
ack_out  in  1  master's ninth bit on READ (0 = ACK, 1 = NACK)
done  out  1  one-cycle pulse when a command completes
ack_err  out  1  slave NACKed the address/data byte; valid at done, held until next done
cmd_err  out  1  illegal command (WRITE/READ/STOP while bus not owned); valid at done, held until next done
read_data  out  8  byte captured by READ; updated at done, held otherwise
bus_owned  out  1  set by START, cleared by STOP
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
sda_in  in  1  sampled SDA line level

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1. Lines are released immediately because reset is asynchronous. Divider and bit counter clear.
- Acceptance:
  - All inputs latch on the accept cycle.
  - The quarter-phase divider restarts at 0 on that cycle.
  - cmd_ready drops the next cycle.
- Phase timing: each phase lasts exactly DIV clocks. Per-bit phases:
  - P0: scl_oe = 1; sda_oe = !bit.
  - P1: scl_oe = 0.
  - P2: SCL high; sda_in sampled on the last clock of P2.
  - P3: scl_oe = 1.
- Bit order: MSB first.
- States: IDLE, START, BITS, ACK, STOP, DONE.
- START (4 phases):
  - SDA released with SCL low.
  - SCL released.
  - sda_oe = 1 with SCL high.
  - scl_oe = 1.
  - Then BITS shifts {slave_addr, mode}, then ACK samples sda_in: ack_err = sampled value. Sets bus_owned.
  - Issued while bus_owned = 1, this produces a repeated start; same waveform.
- WRITE: BITS shifts write_data (8 bits), then ACK samples sda_in into ack_err.
- READ:
  - BITS releases SDA (sda_oe = 0) and shifts sda_in into a register.
  - ACK drives sda_oe = !ack_out.
  - read_data updates at done; ack_err = 0.
- STOP (4 phases):
  - scl_oe = 1, sda_oe = 1.
  - SCL released.
  - SDA released while SCL high.
  - Bus-free hold.
  - Clears bus_owned.
- Latency, accept to done (done in the cycle after the last phase ends; cmd_ready = 1 that same cycle):
  - START: 40*DIV.
  - WRITE/READ: 36*DIV.
  - STOP: 4*DIV.
- Idle line state: between commands with bus_owned = 1, scl_oe stays 1 and sda_oe holds the last ninth-bit value. With bus_owned = 0, both are 0.
- Illegal command: WRITE/READ/STOP with bus_owned = 0 is accepted. done fires the next cycle with cmd_err = 1 and no line activity.
- cmd_valid while busy: ignored; the requester holds it until cmd_ready.
- Reset mid-command: lines are released at once, the command is abandoned, and no done is issued.

Test Plan:
- DIV=2, START addr 0x48, mode 0, sda_in = 0 in ACK slot -> SDA on SCL-high = 1001000 then 0; done 80 cycles after accept; ack_err = 0; bus_owned = 1.
- WRITE 0xA5, sda_in = 1 in ACK slot -> bits 10100101; done at 72 cycles; ack_err = 1; bus_owned stays 1.
- READ, ack_out = 1, slave drives 0x3C -> sda_oe = 0 for all 9 bits; read_data = 0x3C at done; ack_err = 0.
- START while owned, then STOP -> repeated start seen (SDA falls with SCL high); STOP raises SDA with SCL high; done at 8 cycles (DIV=2); bus_owned = 0; scl_oe = sda_oe = 0.
- WRITE with bus_owned = 0 -> done the cycle after accept; cmd_err = 1; scl_oe = sda_oe = 0 throughout.
- reset_n low during bit 3 of a WRITE -> scl_oe = sda_oe = 0 same cycle; cmd_ready = 1; no done; bus_owned = 0.
